int_math_seq: RTL and testbench

//  Synthesizable sequential integer math unit; hardware counterpart of the $clog2/$sqrt/$log system functions.

---
 rtl/int_math_seq.sv | 164 ++++++++++++++++
 tb/tb_int_math_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/int_math_seq.sv
// Sequential integer math unit: ceil-log2, floor-log2 and integer square root
// of an unsigned operand, one request at a time behind valid/ready handshakes.
module int_math_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned CNT_W = $clog2(HALF) + 1;
  localparam int unsigned REM_W = HALF + 2;
  localparam int unsigned SH_W  = REM_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_CLOG2 = 2'd0,
    OP_FLOG2 = 2'd1,
    OP_ISQRT = 2'd2,
    OP_RSVD  = 2'd3
  } op_t;

  state_t           state_q;
  op_t              op_q;
  logic [WIDTH-1:0] x_q;
  logic [REM_W-1:0] rem_q;
  logic [HALF-1:0]  root_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;

  logic [WIDTH-1:0] flog_d;
  logic [WIDTH-1:0] clog_d;
  logic [SH_W-1:0]  rem_shift;
  logic [SH_W-1:0]  trial;
  logic [REM_W-1:0] rem_d;
  logic [HALF-1:0]  root_d;

  function automatic logic [WIDTH-1:0] msb_idx(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = WIDTH'(i);
    end
    return idx;
  endfunction

  always_comb begin
    flog_d = msb_idx(x_q);
    clog_d = (x_q <= WIDTH'(1)) ? '0 : msb_idx(x_q - WIDTH'(1)) + WIDTH'(1);
  end

  // One restoring-sqrt step: bring down the next two operand bits and try
  // subtracting 4*root+1; the remainder never exceeds 2*root, so REM_W holds it.
  always_comb begin
    rem_shift = {rem_q, x_q[WIDTH-1 -: 2]};
    trial     = SH_W'({root_q, 2'b01});
    if (rem_shift >= trial) begin
      rem_d  = REM_W'(rem_shift - trial);
      root_d = {root_q[HALF-2:0], 1'b1};
    end else begin
      rem_d  = REM_W'(rem_shift);
      root_d = {root_q[HALF-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_CLOG2;
      x_q         <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            op_q       <= op_t'(op);
            x_q        <= operand;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CALC: begin
          case (op_q)
            OP_ISQRT: begin
              rem_q  <= rem_d;
              root_q <= root_d;
              x_q    <= x_q << 2;
              cnt_q  <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(HALF - 1)) begin
                result_q    <= WIDTH'(root_d);
                err_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end
            end
            OP_CLOG2: begin
              result_q    <= clog_d;
              err_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
            OP_FLOG2: begin
              result_q    <= (x_q == '0) ? '0 : flog_d;
              err_q       <= (x_q == '0);
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
            default: begin
              result_q    <= '0;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          endcase
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_int_math_seq.sv
// Directed bench for int_math_seq (WIDTH=16): reset, each operation, latency,
// backpressure, ignored busy requests and back-to-back throughput.
module tb_int_math_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] operand;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        err;

  int errors = 0;
  int checks = 0;

  int_math_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Issue one request, then measure edges from the accept edge to out_valid.
  // out_valid is registered on entry to DONE: one edge after accept for log ops
  // (sampled high at the second edge), HALF edges for ISQRT.
  task automatic run(input string tag, input logic [1:0] o, input logic [15:0] x,
                     input logic [15:0] exp_res, input logic exp_err, input int exp_lat);
    int n;
    wait_ready(tag);
    in_valid = 1'b1;
    op       = o;
    operand  = x;
    tick();
    in_valid = 1'b0;
    op       = ~o;
    operand  = ~x;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_res"}, 32'(result), 32'(exp_res));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    tick();
    chk({tag, "_consumed"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int vcnt;
    int badres;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'd0;
    operand   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of an ISQRT
    in_valid = 1'b1; op = 2'd2; operand = 16'd1000;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("midcalc_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_idle", 32'(in_ready), 32'd1);
    repeat (10) tick();
    chk("midrst_no_result", 32'(out_valid), 32'd0);

    // CLOG2
    run("clog2_0",     2'd0, 16'd0,     16'd0,  1'b0, 1);
    run("clog2_1",     2'd0, 16'd1,     16'd0,  1'b0, 1);
    run("clog2_2",     2'd0, 16'd2,     16'd1,  1'b0, 1);
    run("clog2_5",     2'd0, 16'd5,     16'd3,  1'b0, 1);
    run("clog2_7",     2'd0, 16'd7,     16'd3,  1'b0, 1);
    run("clog2_8",     2'd0, 16'd8,     16'd3,  1'b0, 1);
    run("clog2_9",     2'd0, 16'd9,     16'd4,  1'b0, 1);
    run("clog2_65535", 2'd0, 16'hFFFF,  16'd16, 1'b0, 1);

    // FLOOR_LOG2
    run("flog2_1",     2'd1, 16'd1,     16'd0,  1'b0, 1);
    run("flog2_8",     2'd1, 16'd8,     16'd3,  1'b0, 1);
    run("flog2_9",     2'd1, 16'd9,     16'd3,  1'b0, 1);
    run("flog2_32768", 2'd1, 16'h8000,  16'd15, 1'b0, 1);
    run("flog2_0",     2'd1, 16'd0,     16'd0,  1'b1, 1);

    // ISQRT
    run("isqrt_0",     2'd2, 16'd0,     16'd0,   1'b0, 8);
    run("isqrt_1",     2'd2, 16'd1,     16'd1,   1'b0, 8);
    run("isqrt_1000",  2'd2, 16'd1000,  16'd31,  1'b0, 8);
    run("isqrt_65535", 2'd2, 16'hFFFF,  16'd255, 1'b0, 8);
    run("isqrt_24",    2'd2, 16'd24,    16'd4,   1'b0, 8);
    run("isqrt_25",    2'd2, 16'd25,    16'd5,   1'b0, 8);

    // Reserved op
    run("rsvd_123",    2'd3, 16'd123,   16'd0,   1'b1, 1);

    // Backpressure: hold DONE, poke in_valid, nothing must be accepted
    out_ready = 1'b0;
    wait_ready("bp");
    in_valid = 1'b1; op = 2'd0; operand = 16'd9;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      op       = 2'd1;
      operand  = 16'd5;
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", 32'(result), 32'd4);
      chk("bp_hold_err", 32'(err), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release", 32'(out_valid), 32'd0);
    tick();
    chk("bp_idle", 32'(in_ready), 32'd1);
    repeat (4) tick();
    chk("bp_not_queued", 32'(out_valid), 32'd0);

    // Back-to-back CLOG2 with in_valid held: one result every 3 cycles
    in_valid = 1'b1; op = 2'd0; operand = 16'd5;
    vcnt = 0;
    badres = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) begin
        vcnt++;
        if (result !== 16'd3) badres++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", 32'(vcnt), 32'd4);
    chk("b2b_badres", 32'(badres), 32'd0);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
